// File: rtl/text_write_sequencer_if.sv
// Bundle of the UART byte handshake, cursor command pulses and the text-buffer RAM write port.
// Latency: none, wires only.
// Backpressure: the byte is held by the decoder until o_Byte_Release pulses; commands are never stalled.
interface text_write_sequencer_if;
    logic [7:0]  i_Byte;
    logic        i_Byte_Ready;
    logic        o_Byte_Release;
    logic        i_Cmd_Home;
    logic        i_Cmd_Left;
    logic        i_Cmd_Right;
    logic        i_Cmd_Down;
    logic        o_Wr_En;
    logic [11:0] o_Wr_Addr;
    logic [7:0]  o_Wr_Data;
    logic [11:0] o_Cursor;
    logic        o_Busy;

    // Sequencer side.
    modport slave (
        input  i_Byte, i_Byte_Ready,
        input  i_Cmd_Home, i_Cmd_Left, i_Cmd_Right, i_Cmd_Down,
        output o_Byte_Release, o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Cursor, o_Busy
    );

    // Decoder / control side.
    modport master (
        output i_Byte, i_Byte_Ready,
        output i_Cmd_Home, i_Cmd_Left, i_Cmd_Right, i_Cmd_Down,
        input  o_Byte_Release, o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Cursor, o_Busy
    );
endinterface

// File: rtl/text_write_sequencer.sv
// Turns received UART bytes and cursor commands into text-buffer RAM writes and cursor moves.
// Latency: printable byte -> write 2 cycles after the Ready edge is sampled, release 1 cycle later.
// Backpressure: byte held by decoder until o_Byte_Release; optional screen clear (macro TEXT_CLEAR_EN).
module text_write_sequencer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    text_write_sequencer_if.slave  bus
);

    localparam logic [11:0] COLS12   = 12'(COLS);
    localparam logic [11:0] COLS_M1  = 12'(COLS - 1);
    localparam logic [11:0] CELLS12  = 12'(COLS * ROWS);
    localparam logic [11:0] CELLS_M1 = 12'(COLS * ROWS - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_CR    = 8'h0D;
`ifdef TEXT_CLEAR_EN
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        WRITE   = 3'd2,
        ADVANCE = 3'd3,
        RELEASE = 3'd4
`ifdef TEXT_CLEAR_EN
        ,
        CLEAR   = 3'd5
`endif
    } state_e;

    typedef enum logic [1:0] {
        CMD_HOME  = 2'd0,
        CMD_LEFT  = 2'd1,
        CMD_RIGHT = 2'd2,
        CMD_DOWN  = 2'd3
    } cmd_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_ready_prev;
    logic        r_pend;
    logic [7:0]  r_byte;
    logic        r_cmd_vld;
    cmd_e        r_cmd;
    logic [11:0] r_cursor;
    logic [11:0] r_col;
    logic        r_wr_en;
    logic [11:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_release;

    logic        w_byte_edge;
    logic        w_cmd_pulse;
    cmd_e        w_cmd_code;
    logic        w_pend_clr;
    logic        w_cmd_clr;
    logic [7:0]  w_byte_nxt;
    logic [11:0] w_cursor_nxt;
    logic [11:0] w_col_nxt;
    logic        w_wr_en_nxt;
    logic [11:0] w_wr_addr_nxt;
    logic [7:0]  w_wr_data_nxt;
    logic        w_release_nxt;

    // Candidate cursor positions; the column is tracked alongside so CR needs no divider.
    logic [11:0] w_cur_inc, w_col_inc;
    logic [11:0] w_cur_dec, w_col_dec;
    logic [11:0] w_down_sum, w_cur_down;
    logic [11:0] w_cr_sum, w_cur_cr;

    assign w_byte_edge = bus.i_Byte_Ready & ~r_ready_prev;
    assign w_cmd_pulse = bus.i_Cmd_Home | bus.i_Cmd_Left | bus.i_Cmd_Right | bus.i_Cmd_Down;

    // Pick the highest-priority command among simultaneous pulses.
    always_comb begin
        w_cmd_code = CMD_DOWN;
        if (bus.i_Cmd_Home)       w_cmd_code = CMD_HOME;
        else if (bus.i_Cmd_Left)  w_cmd_code = CMD_LEFT;
        else if (bus.i_Cmd_Right) w_cmd_code = CMD_RIGHT;
    end

    // Wrapping cursor arithmetic, all kept within 0..CELLS-1.
    always_comb begin
        w_cur_inc  = (r_cursor == CELLS_M1) ? 12'd0 : r_cursor + 12'd1;
        w_col_inc  = (r_col == COLS_M1) ? 12'd0 : r_col + 12'd1;
        w_cur_dec  = (r_cursor == 12'd0) ? CELLS_M1 : r_cursor - 12'd1;
        w_col_dec  = (r_col == 12'd0) ? COLS_M1 : r_col - 12'd1;
        w_down_sum = r_cursor + COLS12;
        w_cur_down = (w_down_sum >= CELLS12) ? w_down_sum - CELLS12 : w_down_sum;
        w_cr_sum   = r_cursor - r_col + COLS12;
        w_cur_cr   = (w_cr_sum >= CELLS12) ? w_cr_sum - CELLS12 : w_cr_sum;
    end

    // Next-state and next-output decisions for the byte/command sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_pend_clr    = 1'b0;
        w_cmd_clr     = 1'b0;
        w_byte_nxt    = r_byte;
        w_cursor_nxt  = r_cursor;
        w_col_nxt     = r_col;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_release_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_cmd_vld) begin
                    // Commands are served ahead of bytes and complete in this cycle.
                    w_cmd_clr = 1'b1;
                    case (r_cmd)
                        CMD_HOME: begin
                            w_cursor_nxt = 12'd0;
                            w_col_nxt    = 12'd0;
                        end
                        CMD_LEFT: begin
                            w_cursor_nxt = w_cur_dec;
                            w_col_nxt    = w_col_dec;
                        end
                        CMD_RIGHT: begin
                            w_cursor_nxt = w_cur_inc;
                            w_col_nxt    = w_col_inc;
                        end
                        default: begin
                            w_cursor_nxt = w_cur_down;
                        end
                    endcase
                end else if (r_pend) begin
                    w_pend_clr  = 1'b1;
                    w_byte_nxt  = bus.i_Byte;
                    w_state_nxt = DECODE;
                end
            end

            DECODE: begin
                if (r_byte == CH_BS || r_byte == CH_CR) begin
                    w_state_nxt = ADVANCE;
`ifdef TEXT_CLEAR_EN
                end else if (r_byte == CH_FF) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = 12'd0;
                    w_wr_data_nxt = CH_SPACE;
                    w_state_nxt   = CLEAR;
`endif
                end else begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_cursor;
                    w_wr_data_nxt = r_byte;
                    w_state_nxt   = WRITE;
                end
            end

            // The write cycle also steps the cursor so the release follows directly.
            WRITE: begin
                w_cursor_nxt  = w_cur_inc;
                w_col_nxt     = w_col_inc;
                w_release_nxt = 1'b1;
                w_state_nxt   = RELEASE;
            end

            ADVANCE: begin
                if (r_byte == CH_BS) begin
                    w_cursor_nxt = w_cur_dec;
                    w_col_nxt    = w_col_dec;
                end else begin
                    w_cursor_nxt = w_cur_cr;
                    w_col_nxt    = 12'd0;
                end
                w_release_nxt = 1'b1;
                w_state_nxt   = RELEASE;
            end

`ifdef TEXT_CLEAR_EN
            // Sweep every cell with a space, one per cycle, then home the cursor.
            CLEAR: begin
                if (r_wr_addr == CELLS_M1) begin
                    w_cursor_nxt  = 12'd0;
                    w_col_nxt     = 12'd0;
                    w_release_nxt = 1'b1;
                    w_state_nxt   = RELEASE;
                end else begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_wr_addr + 12'd1;
                end
            end
`endif

            RELEASE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state   <= IDLE;
            r_byte    <= 8'd0;
            r_cursor  <= 12'd0;
            r_col     <= 12'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 12'd0;
            r_wr_data <= 8'd0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_byte    <= w_byte_nxt;
            r_cursor  <= w_cursor_nxt;
            r_col     <= w_col_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Byte-ready edge detector and one-deep pending flag; a new edge wins over a clear.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_ready_prev <= 1'b0;
            r_pend       <= 1'b0;
        end else begin
            r_ready_prev <= bus.i_Byte_Ready;
            if (w_byte_edge)     r_pend <= 1'b1;
            else if (w_pend_clr) r_pend <= 1'b0;
        end
    end

    // One-deep command slot; a fresh pulse overwrites whatever is waiting.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_cmd_vld <= 1'b0;
            r_cmd     <= CMD_HOME;
        end else begin
            if (w_cmd_pulse) begin
                r_cmd_vld <= 1'b1;
                r_cmd     <= w_cmd_code;
            end else if (w_cmd_clr) begin
                r_cmd_vld <= 1'b0;
            end
        end
    end

    assign bus.o_Wr_En        = r_wr_en;
    assign bus.o_Wr_Addr      = r_wr_addr;
    assign bus.o_Wr_Data      = r_wr_data;
    assign bus.o_Byte_Release = r_release;
    assign bus.o_Cursor       = r_cursor;
    assign bus.o_Busy         = (r_state != IDLE);

endmodule

// File: tb/tb_text_write_sequencer.sv
// Directed bench for text_write_sequencer: byte path, cursor commands, wrap cases and reset abort.
// Latency checked on the first printable byte; every wait is cycle-bounded.
// The form-feed scenario follows whichever build of TEXT_CLEAR_EN is compiled.
module tb_text_write_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    text_write_sequencer_if bus();

    text_write_sequencer #(.COLS(80), .ROWS(30)) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of one monitored byte sequence.
    int          s_nwr;
    int          s_nrel;
    int          s_wr_i;
    int          s_rel_i;
    logic [11:0] s_a0;
    logic [7:0]  s_d0;
    bit          s_done;
    bit          s_contig;

    task automatic run_seq(input int budget);
        s_nwr = 0; s_nrel = 0; s_wr_i = -1; s_rel_i = -1;
        s_a0 = '0; s_d0 = '0; s_done = 0; s_contig = 1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.o_Wr_En) begin
                if (s_nwr == 0) begin
                    s_a0 = bus.o_Wr_Addr; s_d0 = bus.o_Wr_Data; s_wr_i = i;
                end else if (bus.o_Wr_Addr !== 12'(s_a0 + s_nwr) || bus.o_Wr_Data !== s_d0) begin
                    s_contig = 0;
                end
                s_nwr++;
            end
            if (bus.o_Byte_Release) begin
                if (s_nrel == 0) s_rel_i = i;
                s_nrel++;
            end
            if (i >= 1 && !bus.o_Busy) begin
                s_done = 1;
                break;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int budget);
        @(posedge clk); #1;
        bus.i_Byte = b;
        bus.i_Byte_Ready = 1'b1;
        run_seq(budget);
        bus.i_Byte_Ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (!s_done) begin
            errors++;
            $display("FAIL seq_done byte=%h: sequence did not finish in %0d cycles", b, budget);
        end
    endtask

    task automatic pulse(input logic h, input logic l, input logic r, input logic d);
        @(posedge clk); #1;
        bus.i_Cmd_Home = h; bus.i_Cmd_Left = l; bus.i_Cmd_Right = r; bus.i_Cmd_Down = d;
        @(posedge clk); #1;
        bus.i_Cmd_Home = 0; bus.i_Cmd_Left = 0; bus.i_Cmd_Right = 0; bus.i_Cmd_Down = 0;
        @(posedge clk); #1;
    endtask

    task automatic set_cursor(input int target);
        pulse(1, 0, 0, 0);
        for (int k = 0; k < target / 80; k++) pulse(0, 0, 0, 1);
        for (int k = 0; k < target % 80; k++) pulse(0, 0, 1, 0);
    endtask

    task automatic chk_cursor(input string name, input int exp);
        checks++;
        if (bus.o_Cursor !== 12'(exp)) begin
            errors++;
            $display("FAIL %s: cursor=%0d expected %0d", name, bus.o_Cursor, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_int("rst_busy", int'(bus.o_Busy), 0);
        chk_int("rst_wr_en", int'(bus.o_Wr_En), 0);
        chk_int("rst_release", int'(bus.o_Byte_Release), 0);
        chk_int("rst_wr_addr", int'(bus.o_Wr_Addr), 0);
        chk_int("rst_wr_data", int'(bus.o_Wr_Data), 0);
        chk_cursor("rst_cursor", 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_printable();
        send_byte(8'h41, 20);
        chk_int("A_nwr", s_nwr, 1);
        chk_int("A_addr", int'(s_a0), 0);
        chk_int("A_data", int'(s_d0), 'h41);
        chk_int("A_wr_latency", s_wr_i, 2);
        chk_int("A_rel_latency", s_rel_i, 3);
        chk_int("A_nrel", s_nrel, 1);
        chk_cursor("A_cursor", 1);
    endtask

    task automatic test_wrap();
        set_cursor(2399);
        send_byte(8'h42, 20);
        chk_int("wrap_nwr", s_nwr, 1);
        chk_int("wrap_addr", int'(s_a0), 2399);
        chk_cursor("wrap_cursor", 0);
        send_byte(8'h08, 20);
        chk_int("bs_nwr", s_nwr, 0);
        chk_int("bs_nrel", s_nrel, 1);
        chk_cursor("bs_cursor", 2399);
    endtask

    task automatic test_cr();
        set_cursor(2365);
        send_byte(8'h0D, 20);
        chk_int("cr_last_nwr", s_nwr, 0);
        chk_cursor("cr_last_cursor", 0);
        set_cursor(85);
        send_byte(8'h0D, 20);
        chk_cursor("cr_mid_cursor", 160);
    endtask

    task automatic test_commands();
        // Left and Down arrive together while a CR is in DECODE; only Left may be served.
        set_cursor(2365);
        @(posedge clk); #1;
        bus.i_Byte = 8'h0D; bus.i_Byte_Ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_int("cmd_busy_in_seq", int'(bus.o_Busy), 1);
        bus.i_Cmd_Left = 1'b1; bus.i_Cmd_Down = 1'b1;
        @(posedge clk); #1;
        bus.i_Cmd_Left = 1'b0; bus.i_Cmd_Down = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.i_Byte_Ready = 1'b0;
        chk_cursor("cmd_left_over_down", 2399);
        chk_int("cmd_idle_after", int'(bus.o_Busy), 0);
        set_cursor(2350);
        pulse(0, 0, 0, 1);
        chk_cursor("cmd_down_wrap", 30);
        pulse(1, 0, 1, 0);
        chk_cursor("cmd_home_over_right", 0);
        pulse(0, 1, 0, 0);
        chk_cursor("cmd_left_wrap", 2399);
        pulse(0, 0, 1, 0);
        chk_cursor("cmd_right_wrap", 0);
    endtask

    task automatic test_form_feed();
`ifdef TEXT_CLEAR_EN
        set_cursor(500);
        send_byte(8'h0C, 3000);
        chk_int("clr_nwr", s_nwr, 2400);
        chk_int("clr_addr0", int'(s_a0), 0);
        chk_int("clr_data", int'(s_d0), 'h20);
        chk_int("clr_contig", int'(s_contig), 1);
        chk_int("clr_nrel", s_nrel, 1);
        chk_cursor("clr_cursor", 0);
        // Abort the sweep at its 1000th write.
        set_cursor(500);
        @(posedge clk); #1;
        bus.i_Byte = 8'h0C; bus.i_Byte_Ready = 1'b1;
        s_nwr = 0;
        for (int i = 0; i < 1200 && s_nwr < 1000; i++) begin
            @(posedge clk); #1;
            if (bus.o_Wr_En) s_nwr++;
        end
        chk_int("clr_abort_reached", s_nwr, 1000);
        rst_n = 1'b0;
        bus.i_Byte_Ready = 1'b0;
        #1;
        chk_int("clr_abort_wr_en", int'(bus.o_Wr_En), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_nrel = 0; s_nwr = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.o_Byte_Release) s_nrel++;
            if (bus.o_Wr_En) s_nwr++;
        end
        chk_int("clr_abort_no_release", s_nrel, 0);
        chk_int("clr_abort_no_write", s_nwr, 0);
`else
        set_cursor(7);
        send_byte(8'h0C, 20);
        chk_int("ff_nwr", s_nwr, 1);
        chk_int("ff_addr", int'(s_a0), 7);
        chk_int("ff_data", int'(s_d0), 'h0C);
        chk_cursor("ff_cursor", 8);
`endif
    endtask

    task automatic test_back_to_back();
        set_cursor(10);
        send_byte(8'h78, 20);
        chk_int("b2b_addr0", int'(s_a0), 10);
        send_byte(8'h79, 20);
        chk_int("b2b_addr1", int'(s_a0), 11);
        chk_int("b2b_data1", int'(s_d0), 'h79);
        chk_cursor("b2b_cursor", 12);
    endtask

    task automatic test_reset_mid();
        set_cursor(20);
        @(posedge clk); #1;
        bus.i_Byte = 8'h5A; bus.i_Byte_Ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_int("mid_rst_busy", int'(bus.o_Busy), 0);
        chk_int("mid_rst_wr_en", int'(bus.o_Wr_En), 0);
        chk_cursor("mid_rst_cursor", 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Ready stayed high across reset, so it must be taken as a fresh byte.
        run_seq(20);
        bus.i_Byte_Ready = 1'b0;
        @(posedge clk); #1;
        chk_int("mid_rst_refire_done", int'(s_done), 1);
        chk_int("mid_rst_refire_nwr", s_nwr, 1);
        chk_int("mid_rst_refire_addr", int'(s_a0), 0);
        chk_int("mid_rst_refire_data", int'(s_d0), 'h5A);
        chk_cursor("mid_rst_refire_cursor", 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_Byte = 8'h00;
        bus.i_Byte_Ready = 1'b0;
        bus.i_Cmd_Home = 1'b0;
        bus.i_Cmd_Left = 1'b0;
        bus.i_Cmd_Right = 1'b0;
        bus.i_Cmd_Down = 1'b0;
        test_reset();
        test_printable();
        test_wrap();
        test_cr();
        test_commands();
        test_form_feed();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
